// File: rtl/bit_scan8.sv
// bit_scan8: expands a captured byte into its set-bit indices, one per handshake beat.
// Defining BIT_SCAN8_COUNT_EN adds the out_count (popcount) and out_seq (beat ordinal) outputs.
module bit_scan8 #(
    parameter int MSB_FIRST = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [2:0] out_index,
    output logic       out_last,
    output logic       out_empty,
    output logic       any,
    output logic       busy
`ifdef BIT_SCAN8_COUNT_EN
    ,
    output logic [3:0] out_count,
    output logic [2:0] out_seq
`endif
);
    typedef enum logic {IDLE, SCAN} state_t;
    state_t     r_state, w_next;
    logic [7:0] r_mask;
    logic       r_any;
    logic [2:0] w_idx;
    logic       w_scan, w_capture, w_beat, w_done;
    // Priority pick: the last match in loop order wins, so loop direction sets which end is reported.
    always_comb begin
        w_idx = 3'd0;
        if (MSB_FIRST != 0) begin
            for (int i = 0; i < 8; i++) if (r_mask[i]) w_idx = 3'(i);
        end else begin
            for (int i = 7; i >= 0; i--) if (r_mask[i]) w_idx = 3'(i);
        end
    end
    assign w_scan    = (r_state == SCAN);
    assign out_index = w_scan ? w_idx : 3'd0;
    assign out_last  = w_scan && ((r_mask & (r_mask - 8'd1)) == 8'd0);
    assign out_empty = w_scan && (r_mask == 8'd0);
    assign any       = r_any;
    always_comb begin
        in_ready  = !w_scan;
        out_valid = w_scan;
        busy      = w_scan;
        w_capture = !w_scan && in_valid;
        w_beat    = w_scan && out_ready;
        w_done    = w_beat && out_last;
        w_next    = w_capture ? SCAN : (w_done ? IDLE : r_state);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_mask  <= 8'd0;
            r_any   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_capture) begin
                r_mask <= in_data;
                r_any  <= |in_data;
            end else if (w_beat) begin
                r_mask <= r_mask & ~(8'd1 << w_idx);
                if (w_done) r_any <= 1'b0;
            end
        end
    end
`ifdef BIT_SCAN8_COUNT_EN
    logic [3:0] r_count;
    logic [2:0] r_seq;
    assign out_count = r_count;
    assign out_seq   = r_seq;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 4'd0;
            r_seq   <= 3'd0;
        end else if (w_capture) begin
            r_count <= 4'($countones(in_data));
            r_seq   <= 3'd0;
        end else if (w_done) begin
            r_count <= 4'd0;
            r_seq   <= 3'd0;
        end else if (w_beat) begin
            r_seq <= r_seq + 3'd1;
        end
    end
`endif
endmodule

// File: tb/tb_bit_scan8.sv
// tb_bit_scan8: drives LSB-first and MSB-first instances in lockstep and checks both
// against a set-bit list model; covers BIT_SCAN8_COUNT_EN outputs when defined.
module tb_bit_scan8;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       out_ready = 1'b0;
    logic       ir0, ov0, last0, emp0, any0, busy0;
    logic       ir1, ov1, last1, emp1, any1, busy1;
    logic [2:0] idx0, idx1;
`ifdef BIT_SCAN8_COUNT_EN
    logic [3:0] cnt0, cnt1;
    logic [2:0] seq0, seq1;
`endif
    int checks = 0;
    int errs   = 0;
    int q0[$];
    int q1[$];

    always #5 clk = ~clk;

    bit_scan8 #(.MSB_FIRST(0)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir0), .in_data(in_data),
        .out_valid(ov0), .out_ready(out_ready), .out_index(idx0), .out_last(last0),
        .out_empty(emp0), .any(any0), .busy(busy0)
`ifdef BIT_SCAN8_COUNT_EN
        , .out_count(cnt0), .out_seq(seq0)
`endif
    );

    bit_scan8 #(.MSB_FIRST(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
        .out_valid(ov1), .out_ready(out_ready), .out_index(idx1), .out_last(last1),
        .out_empty(emp1), .any(any1), .busy(busy1)
`ifdef BIT_SCAN8_COUNT_EN
        , .out_count(cnt1), .out_seq(seq1)
`endif
    );

    // Reference: the ordered list of set-bit positions, or a single 0 for an empty word.
    function automatic void build(input logic [7:0] w);
        q0.delete();
        q1.delete();
        for (int i = 0; i < 8; i++) if (w[i]) begin
            q0.push_back(i);
            q1.push_front(i);
        end
        if (w == 8'd0) begin
            q0.push_back(0);
            q1.push_back(0);
        end
    endfunction

    task automatic capture(input logic [7:0] w);
        in_valid = 1'b1;
        in_data  = w;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid  = 1'($urandom);
            in_data   = 8'($urandom);
            out_ready = 1'($urandom);
            @(negedge clk);
            checks++;
            if ({ir0, ov0, busy0, any0, idx0, last0, emp0, ir1, ov1, busy1, any1, idx1, last1, emp1}
                !== {4'b1000, 3'd0, 2'b00, 4'b1000, 3'd0, 2'b00}) begin
                errs++;
                $display("FAIL reset hold %0d: rdy %b/%b vld %b/%b busy %b/%b any %b/%b, want rdy 1 vld 0 busy 0 any 0",
                         k, ir0, ir1, ov0, ov1, busy0, busy1, any0, any1);
            end
        end
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        checks++;
        if (ir0 !== 1'b1 || ov0 !== 1'b0 || ir1 !== 1'b1 || ov1 !== 1'b0) begin
            errs++;
            $display("FAIL reset release: rdy %b/%b vld %b/%b, want rdy 1 vld 0", ir0, ir1, ov0, ov1);
        end
    endtask

    task automatic test_sparse;
        int e0[4] = '{0, 2, 5, 7};
        capture(8'hA5);
        out_ready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            checks++;
            if (ov0 !== 1'b1 || ov1 !== 1'b1 || ir0 !== 1'b0 || int'(idx0) != e0[b] || int'(idx1) != e0[3-b] ||
                last0 !== (b == 3) || last1 !== (b == 3) || any0 !== 1'b1 || emp0 !== 1'b0 || busy0 !== 1'b1) begin
                errs++;
                $display("FAIL sparse beat %0d: vld %b idx %0d/%0d last %b/%b any %b, want vld 1 idx %0d/%0d last %b any 1",
                         b, ov0, idx0, idx1, last0, last1, any0, e0[b], e0[3-b], b == 3);
            end
            @(negedge clk);
        end
        checks++;
        if (ir0 !== 1'b1 || ov0 !== 1'b0 || any0 !== 1'b0 || busy0 !== 1'b0) begin
            errs++;
            $display("FAIL sparse end: rdy %b vld %b any %b busy %b, want rdy 1 vld 0 any 0 busy 0", ir0, ov0, any0, busy0);
        end
    endtask

    task automatic test_zero_single;
        logic [7:0] w [2] = '{8'h00, 8'h80};
        out_ready = 1'b1;
        for (int n = 0; n < 2; n++) begin
            capture(w[n]);
            checks++;
            if (ov0 !== 1'b1 || last0 !== 1'b1 || last1 !== 1'b1 || emp0 !== (n == 0) || emp1 !== (n == 0) ||
                idx0 !== (n == 0 ? 3'd0 : 3'd7) || idx1 !== (n == 0 ? 3'd0 : 3'd7) || any0 !== (n == 1)) begin
                errs++;
                $display("FAIL single %02h: vld %b idx %0d/%0d last %b/%b empty %b/%b any %b",
                         w[n], ov0, idx0, idx1, last0, last1, emp0, emp1, any0);
            end
            @(negedge clk);
            checks++;
            if (ov0 !== 1'b0 || ov1 !== 1'b0 || ir0 !== 1'b1 || emp0 !== 1'b0 || any0 !== 1'b0) begin
                errs++;
                $display("FAIL single %02h end: vld %b/%b rdy %b empty %b any %b, want vld 0 rdy 1 empty 0 any 0",
                         w[n], ov0, ov1, ir0, emp0, any0);
            end
        end
    endtask

    task automatic test_backpressure;
        logic pat [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        int b = 0;
        capture(8'h0F);
        for (int k = 0; k < 7; k++) begin
            checks++;
            if (ov0 !== 1'b1 || int'(idx0) != b || int'(idx1) != 3 - b || last0 !== (b == 3) || last1 !== (b == 3)) begin
                errs++;
                $display("FAIL backpressure cycle %0d: vld %b idx %0d/%0d last %b/%b, want vld 1 idx %0d/%0d last %b",
                         k, ov0, idx0, idx1, last0, last1, b, 3 - b, b == 3);
            end
            out_ready = pat[k];
            if (pat[k]) b++;
            @(negedge clk);
        end
        checks++;
        if (ov0 !== 1'b0 || ov1 !== 1'b0 || ir0 !== 1'b1) begin
            errs++;
            $display("FAIL backpressure end: vld %b/%b rdy %b, want vld 0 rdy 1", ov0, ov1, ir0);
        end
    endtask

    task automatic test_reset_mid;
        capture(8'hFF);
        out_ready = 1'b1;
        for (int b = 0; b < 3; b++) begin
            checks++;
            if (ov0 !== 1'b1 || int'(idx0) != b || int'(idx1) != 7 - b || last0 !== 1'b0) begin
                errs++;
                $display("FAIL midreset beat %0d: vld %b idx %0d/%0d last %b, want vld 1 idx %0d/%0d last 0",
                         b, ov0, idx0, idx1, last0, b, 7 - b);
            end
            @(negedge clk);
        end
        out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (ov0 !== 1'b0 || ov1 !== 1'b0 || ir0 !== 1'b1 || busy0 !== 1'b0 || any0 !== 1'b0 || any1 !== 1'b0) begin
            errs++;
            $display("FAIL midreset async: vld %b/%b rdy %b busy %b any %b/%b, want vld 0 rdy 1 busy 0 any 0",
                     ov0, ov1, ir0, busy0, any0, any1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        capture(8'h02);
        out_ready = 1'b1;
        checks++;
        if (ov0 !== 1'b1 || idx0 !== 3'd1 || idx1 !== 3'd1 || last0 !== 1'b1 || last1 !== 1'b1) begin
            errs++;
            $display("FAIL midreset next: vld %b idx %0d/%0d last %b/%b, want vld 1 idx 1/1 last 1", ov0, idx0, idx1, last0, last1);
        end
        @(negedge clk);
        checks++;
        if (ov0 !== 1'b0 || ir0 !== 1'b1) begin
            errs++;
            $display("FAIL midreset end: vld %b rdy %b, want vld 0 rdy 1", ov0, ir0);
        end
    endtask

    task automatic test_back_to_back;
        int e0[2][2] = '{'{0, 4}, '{0, 1}};
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h11;
        @(negedge clk);
        for (int n = 0; n < 2; n++) begin
            in_data = 8'h03;
            for (int b = 0; b < 2; b++) begin
                checks++;
                if (ov0 !== 1'b1 || int'(idx0) != e0[n][b] || int'(idx1) != e0[n][1-b] || last0 !== (b == 1) || last1 !== (b == 1)
`ifdef BIT_SCAN8_COUNT_EN
                    || cnt0 !== 4'd2 || cnt1 !== 4'd2 || int'(seq0) != b || int'(seq1) != b
`endif
                    ) begin
                    errs++;
                    $display("FAIL b2b word %0d beat %0d: vld %b idx %0d/%0d last %b/%b, want vld 1 idx %0d/%0d last %b",
                             n, b, ov0, idx0, idx1, last0, last1, e0[n][b], e0[n][1-b], b == 1);
                end
                @(negedge clk);
            end
            if (n == 1) in_valid = 1'b0;
            checks++;
            if (ov0 !== 1'b0 || ov1 !== 1'b0 || ir0 !== 1'b1 || busy0 !== 1'b0) begin
                errs++;
                $display("FAIL b2b gap %0d: vld %b/%b rdy %b busy %b, want vld 0 rdy 1 busy 0", n, ov0, ov1, ir0, busy0);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random;
        logic [7:0] w;
        int b, guard;
        for (int n = 0; n < 60; n++) begin
            w = 8'($urandom);
            if (n % 7 == 0) w = 8'd1 << $urandom_range(0, 7);
            build(w);
            capture(w);
            b = 0;
            guard = 0;
            while (b < q0.size() && guard < 200) begin
                checks++;
                if (ov0 !== 1'b1 || ov1 !== 1'b1 || ir0 !== 1'b0 || busy1 !== 1'b1 || int'(idx0) != q0[b] || int'(idx1) != q1[b] ||
                    last0 !== (b == q0.size() - 1) || last1 !== (b == q1.size() - 1) ||
                    emp0 !== (w == 8'd0) || emp1 !== (w == 8'd0) || any0 !== (w != 8'd0) || any1 !== (w != 8'd0)
`ifdef BIT_SCAN8_COUNT_EN
                    || int'(cnt0) != $countones(w) || int'(cnt1) != $countones(w) || int'(seq0) != b || int'(seq1) != b
`endif
                    ) begin
                    errs++;
                    $display("FAIL random %02h beat %0d: vld %b idx %0d/%0d last %b/%b empty %b any %b, want idx %0d/%0d last %b",
                             w, b, ov0, idx0, idx1, last0, last1, emp0, any0, q0[b], q1[b], b == q0.size() - 1);
                end
                out_ready = ($urandom_range(0, 3) != 0);
                in_valid  = 1'($urandom);
                in_data   = 8'($urandom);
                if (out_ready) b++;
                guard++;
                @(negedge clk);
            end
            in_valid = 1'b0;
            checks++;
            if (guard >= 200 || ov0 !== 1'b0 || ov1 !== 1'b0 || ir0 !== 1'b1 || ir1 !== 1'b1 || any0 !== 1'b0) begin
                errs++;
                $display("FAIL random %02h end: vld %b/%b rdy %b/%b any %b cycles %0d, want vld 0 rdy 1 any 0",
                         w, ov0, ov1, ir0, ir1, any0, guard);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_sparse();
        test_zero_single();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
        $finish;
    end
endmodule
